ysyx_25020032_axi_arbiter: RTL and testbench
============================================

# ysyx_25020032_axi_arbiter

Two-master, one-slave AXI4 arbiter. It lets the IFU (instruction fetch, read-only) and the LSU/WBU (data load/store, read and write) share the core's single AXI master port to the memory/crossbar. Only one transaction is outstanding at a time. Arbitration is round-robin between the two requesters, and the granted master's channels are passed straight through until its response completes.

## Interface
Parameters
- ADDR_W, 32, address width on all AR/AW channels
- DATA_W, 32, data width on R/W channels; strobe width DATA_W/8
- ID_W, 4, AXI ID width, passed through unchanged

Ports
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ifu_ar*  in/out  araddr[ADDR_W], arvalid, arready(out), arid[ID_W], arlen[8], arsize[3], arburst[2]  IFU read address
- ifu_r*  out/in  rdata[DATA_W], rresp[2], rid[ID_W], rlast, rvalid(out), rready(in)  IFU read data
- lsu_ar*, lsu_r*  same shapes as IFU  LSU read channels
- lsu_aw*  in/out  awaddr, awvalid, awready(out), awid, awlen, awsize, awburst  LSU write address
- lsu_w*  in/out  wdata[DATA_W], wstrb[DATA_W/8], wlast, wvalid, wready(out)  LSU write data
- lsu_b*  out/in  bresp[2], bid[ID_W], bvalid(out), bready(in)  LSU write response
- m_ar*, m_r*, m_aw*, m_w*, m_b*  mirror of the above  downstream master port
- grant  out  2  current owner: 00 none, 01 IFU, 10 LSU
- busy  out  1  state != IDLE

## Operation
- States: IDLE, IFU_RD, LSU_RD, LSU_WR; registered, async reset to IDLE.
- IDLE:
  - Requests are ifu_req = ifu_arvalid and lsu_req = lsu_arvalid | (lsu_awvalid & lsu_wvalid).
  - If only one master requests, it is granted.
  - If both request, the master not granted last time wins. The last_grant register resets to IFU, so the LSU wins the first tie.
  - An LSU grant goes to LSU_WR if AW+W are both valid, otherwise to LSU_RD. Write takes precedence if the LSU asserts both.
  - The last_grant register updates on entering any grant state.
- IFU_RD / LSU_RD:
  - The granted master's AR and R channels are combinationally connected to m_ar / m_r.
  - All other downstream valids and all other upstream readys/valids are forced to 0.
  - Return to IDLE on the m_rvalid & m_rready & m_rlast handshake.
- LSU_WR:
  - LSU AW, W and B are connected to m_aw / m_w / m_b.
  - AW and W may complete in either order; the arbiter does not track them.
  - Return to IDLE on the m_bvalid & m_bready handshake.
- Non-granted masters see arready/awready/wready = 0 and rvalid/bvalid = 0. AXI requires them to hold their valids.
- rresp, bresp and IDs pass through unmodified. Error responses end the transaction normally.
- Reset values:
  - All m_*valid = 0, m_rready = m_bready = 0.
  - All upstream *ready = 0, ifu_rvalid = lsu_rvalid = lsu_bvalid = 0.
  - grant = 00, busy = 0.

## Timing
- Arbitration costs one cycle. A request seen in IDLE at edge N appears on m_* in cycle N+1, not combinationally in cycle N.
- Pass-through is zero-latency within a grant state. There is no buffering, so downstream back-pressure propagates directly.
- The completing handshake cycle is the last cycle of the grant. The state is IDLE in the following cycle, and a new grant is possible one cycle after that. Back-to-back turnaround is therefore 2 cycles from last beat to next AR/AW.
- A request arriving in the same cycle a transaction completes is arbitrated on the next IDLE cycle, under round-robin.
- Bursts (arlen>0): the grant is held until rlast. Writes are single-beat (awlen=0); wlast is passed through and not checked.
- Reset mid-transaction:
  - All outputs drop to reset values immediately, with no clock needed.
  - The downstream transaction is abandoned. Downstream is reset by the same rst.
- ifu_ar* values must not be sampled in IDLE. Only valid matters for arbitration.

## Test plan
- IFU only: ifu_araddr=0x8000_0000, arvalid=1 at cycle 0.
  - Required: grant=01 and m_arvalid=1 with m_araddr=0x8000_0000 at cycle 1.
  - rdata=0x0000_0413 with rlast is returned to ifu_rdata; state returns to IDLE the cycle after.
- Simultaneous requests after reset: IFU read and LSU read at 0x8000_1000.
  - Required: LSU granted first (grant=10).
  - After its R completes, the IFU is granted with a 2-cycle gap and ifu_arvalid held throughout.
- LSU store: awaddr=0xA000_03F8, wdata=0x41, wstrb=0001, AW and W valid.
  - Required: state LSU_WR; m_wstrb=0001.
  - lsu_bvalid mirrors m_bvalid; IDLE after the B handshake.
- Fairness: IFU and LSU request continuously for 6 transactions.
  - Required: grants alternate 10,01,10,01,10,01; neither master is starved.
- Back-pressure / error: m_rvalid delayed 5 cycles, then rresp=10 (SLVERR).
  - Required: the grant is held for all 5 wait cycles; the IFU receives rresp=10 and the arbiter returns to IDLE.
- Reset mid-read: assert rst while in IFU_RD with m_arvalid=1.
  - Required: m_arvalid, grant and busy go to 0 in the same cycle; after release, a new request is granted normally.

Source files
------------

// File: rtl/ysyx_25020032_axi_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4 arbiter.
// Round-robin grant, single outstanding transaction, zero-latency pass-through.
module ysyx_25020032_axi_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                clk,
    input  logic                rst,
    // IFU read address / data
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [ID_W-1:0]     ifu_arid,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    input  logic [1:0]          ifu_arburst,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    output logic [ID_W-1:0]     ifu_rid,
    output logic                ifu_rlast,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    // LSU read address / data
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    input  logic [ID_W-1:0]     lsu_arid,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    input  logic [1:0]          lsu_arburst,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    output logic [ID_W-1:0]     lsu_rid,
    output logic                lsu_rlast,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    // LSU write address / data / response
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [ID_W-1:0]     lsu_awid,
    input  logic [7:0]          lsu_awlen,
    input  logic [2:0]          lsu_awsize,
    input  logic [1:0]          lsu_awburst,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    output logic [1:0]          lsu_bresp,
    output logic [ID_W-1:0]     lsu_bid,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    // Downstream master port
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ID_W-1:0]     m_arid,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic [ID_W-1:0]     m_rid,
    input  logic                m_rlast,
    input  logic                m_rvalid,
    output logic                m_rready,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ID_W-1:0]     m_awid,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic [ID_W-1:0]     m_bid,
    input  logic                m_bvalid,
    output logic                m_bready,
    // Status
    output logic [1:0]          grant,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   last_lsu;

    logic ifu_req, lsu_wr_req, lsu_req;
    logic r_done, b_done;
    state_t lsu_target;

    assign ifu_req    = ifu_arvalid;
    assign lsu_wr_req = lsu_awvalid & lsu_wvalid;
    assign lsu_req    = lsu_arvalid | lsu_wr_req;
    assign lsu_target = lsu_wr_req ? LSU_WR : LSU_RD;
    assign r_done     = m_rvalid & m_rready & m_rlast;
    assign b_done     = m_bvalid & m_bready;

    // State and round-robin history; last_lsu resets to "IFU granted last"
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last_lsu <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx != IDLE)
                last_lsu <= (state_nx != IFU_RD);
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (ifu_req && lsu_req)
                    state_nx = last_lsu ? IFU_RD : lsu_target;
                else if (ifu_req)
                    state_nx = IFU_RD;
                else if (lsu_req)
                    state_nx = lsu_target;
            end
            IFU_RD, LSU_RD: if (r_done) state_nx = IDLE;
            LSU_WR:         if (b_done) state_nx = IDLE;
            default:        state_nx = IDLE;
        endcase
    end

    always_comb begin
        m_araddr    = '0;
        m_arvalid   = 1'b0;
        m_arid      = '0;
        m_arlen     = '0;
        m_arsize    = '0;
        m_arburst   = '0;
        m_rready    = 1'b0;
        m_awaddr    = '0;
        m_awvalid   = 1'b0;
        m_awid      = '0;
        m_awlen     = '0;
        m_awsize    = '0;
        m_awburst   = '0;
        m_wdata     = '0;
        m_wstrb     = '0;
        m_wlast     = 1'b0;
        m_wvalid    = 1'b0;
        m_bready    = 1'b0;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = '0;
        ifu_rid     = '0;
        ifu_rlast   = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = '0;
        lsu_rid     = '0;
        lsu_rlast   = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bresp   = '0;
        lsu_bid     = '0;
        lsu_bvalid  = 1'b0;
        grant       = 2'b00;
        busy        = (state != IDLE);
        unique case (state)
            IFU_RD: begin
                grant       = 2'b01;
                m_araddr    = ifu_araddr;
                m_arvalid   = ifu_arvalid;
                m_arid      = ifu_arid;
                m_arlen     = ifu_arlen;
                m_arsize    = ifu_arsize;
                m_arburst   = ifu_arburst;
                m_rready    = ifu_rready;
                ifu_arready = m_arready;
                ifu_rdata   = m_rdata;
                ifu_rresp   = m_rresp;
                ifu_rid     = m_rid;
                ifu_rlast   = m_rlast;
                ifu_rvalid  = m_rvalid;
            end
            LSU_RD: begin
                grant       = 2'b10;
                m_araddr    = lsu_araddr;
                m_arvalid   = lsu_arvalid;
                m_arid      = lsu_arid;
                m_arlen     = lsu_arlen;
                m_arsize    = lsu_arsize;
                m_arburst   = lsu_arburst;
                m_rready    = lsu_rready;
                lsu_arready = m_arready;
                lsu_rdata   = m_rdata;
                lsu_rresp   = m_rresp;
                lsu_rid     = m_rid;
                lsu_rlast   = m_rlast;
                lsu_rvalid  = m_rvalid;
            end
            LSU_WR: begin
                grant       = 2'b10;
                m_awaddr    = lsu_awaddr;
                m_awvalid   = lsu_awvalid;
                m_awid      = lsu_awid;
                m_awlen     = lsu_awlen;
                m_awsize    = lsu_awsize;
                m_awburst   = lsu_awburst;
                m_wdata     = lsu_wdata;
                m_wstrb     = lsu_wstrb;
                m_wlast     = lsu_wlast;
                m_wvalid    = lsu_wvalid;
                m_bready    = lsu_bready;
                lsu_awready = m_awready;
                lsu_wready  = m_wready;
                lsu_bresp   = m_bresp;
                lsu_bid     = m_bid;
                lsu_bvalid  = m_bvalid;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_25020032_axi_arbiter.sv
// Directed self-checking bench for ysyx_25020032_axi_arbiter.
// Inputs change 1ns after posedge; outputs are checked before the next edge.
module tb_ysyx_25020032_axi_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid, ifu_arready;
    logic [3:0]  ifu_arid;
    logic [7:0]  ifu_arlen;
    logic [2:0]  ifu_arsize;
    logic [1:0]  ifu_arburst;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic [3:0]  ifu_rid;
    logic        ifu_rlast, ifu_rvalid, ifu_rready;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid, lsu_arready;
    logic [3:0]  lsu_arid;
    logic [7:0]  lsu_arlen;
    logic [2:0]  lsu_arsize;
    logic [1:0]  lsu_arburst;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic [3:0]  lsu_rid;
    logic        lsu_rlast, lsu_rvalid, lsu_rready;
    logic [31:0] lsu_awaddr;
    logic        lsu_awvalid, lsu_awready;
    logic [3:0]  lsu_awid;
    logic [7:0]  lsu_awlen;
    logic [2:0]  lsu_awsize;
    logic [1:0]  lsu_awburst;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wlast, lsu_wvalid, lsu_wready;
    logic [1:0]  lsu_bresp;
    logic [3:0]  lsu_bid;
    logic        lsu_bvalid, lsu_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid, m_arready;
    logic [3:0]  m_arid;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic [3:0]  m_rid;
    logic        m_rlast, m_rvalid, m_rready;
    logic [31:0] m_awaddr;
    logic        m_awvalid, m_awready;
    logic [3:0]  m_awid;
    logic [7:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awburst;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wlast, m_wvalid, m_wready;
    logic [1:0]  m_bresp;
    logic [3:0]  m_bid;
    logic        m_bvalid, m_bready;
    logic [1:0]  grant;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_25020032_axi_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid),
        .ifu_arready(ifu_arready), .ifu_arid(ifu_arid),
        .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize),
        .ifu_arburst(ifu_arburst), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rid(ifu_rid),
        .ifu_rlast(ifu_rlast), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid),
        .lsu_arready(lsu_arready), .lsu_arid(lsu_arid),
        .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize),
        .lsu_arburst(lsu_arburst), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rid(lsu_rid),
        .lsu_rlast(lsu_rlast), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid),
        .lsu_awready(lsu_awready), .lsu_awid(lsu_awid),
        .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize),
        .lsu_awburst(lsu_awburst), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bid(lsu_bid),
        .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_arid(m_arid),
        .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rid(m_rid),
        .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_awid(m_awid),
        .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bid(m_bid),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start in IDLE with the requester's valid already up; serve one read.
    task automatic read_txn(input logic [1:0] g, input logic [31:0] a,
                            input logic [31:0] d, input logic [1:0] rs,
                            input int waits, input int beats);
        tick();
        chk("rd_grant", grant, g);
        chk("rd_busy", busy, 1);
        chk("rd_m_arvalid", m_arvalid, 1);
        chk("rd_m_araddr", m_araddr, a);
        m_arready = 1'b1;
        #1;
        chk("rd_arready_own", (g == 2'b01) ? ifu_arready : lsu_arready, 1);
        chk("rd_arready_other", (g == 2'b01) ? lsu_arready : ifu_arready, 0);
        tick();
        m_arready = 1'b0;
        repeat (waits) begin
            chk("rd_wait_grant", grant, g);
            chk("rd_wait_rvalid", (g == 2'b01) ? ifu_rvalid : lsu_rvalid, 0);
            tick();
        end
        for (int b = 0; b < beats; b++) begin
            m_rvalid = 1'b1;
            m_rdata  = d + b;
            m_rresp  = rs;
            m_rid    = 4'h5;
            m_rlast  = (b == beats - 1);
            #1;
            chk("rd_rvalid_own", (g == 2'b01) ? ifu_rvalid : lsu_rvalid, 1);
            chk("rd_rvalid_other", (g == 2'b01) ? lsu_rvalid : ifu_rvalid, 0);
            chk("rd_rdata", (g == 2'b01) ? ifu_rdata : lsu_rdata, d + b);
            chk("rd_rresp", (g == 2'b01) ? ifu_rresp : lsu_rresp, rs);
            chk("rd_m_rready", m_rready, 1);
            tick();
            m_rvalid = 1'b0;
            m_rlast  = 1'b0;
            if (b < beats - 1) chk("rd_burst_hold", grant, g);
        end
        chk("rd_end_grant", grant, 0);
        chk("rd_end_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        {ifu_araddr, ifu_arvalid, ifu_arid, ifu_arlen} = '0;
        {ifu_arsize, ifu_arburst, ifu_rready} = '0;
        {lsu_araddr, lsu_arvalid, lsu_arid, lsu_arlen} = '0;
        {lsu_arsize, lsu_arburst, lsu_rready} = '0;
        {lsu_awaddr, lsu_awvalid, lsu_awid, lsu_awlen} = '0;
        {lsu_awsize, lsu_awburst, lsu_wdata, lsu_wstrb} = '0;
        {lsu_wlast, lsu_wvalid, lsu_bready} = '0;
        {m_arready, m_rdata, m_rresp, m_rid, m_rlast, m_rvalid} = '0;
        {m_awready, m_wready, m_bresp, m_bid, m_bvalid} = '0;
        #23;
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_rready", m_rready, 0);
        chk("rst_ifu_arready", ifu_arready, 0);
        rst = 1'b0;
        tick();

        // IFU only; arbitration costs one cycle
        ifu_araddr  = 32'h8000_0000;
        ifu_arvalid = 1'b1;
        ifu_rready  = 1'b1;
        lsu_rready  = 1'b1;
        #1;
        chk("ifu_req_not_comb", m_arvalid, 0);
        read_txn(2'b01, 32'h8000_0000, 32'h0000_0413, 2'b00, 0, 1);
        ifu_arvalid = 1'b0;
        tick();
        chk("idle_stays", busy, 0);

        // Tie: LSU wins (IFU granted last), then IFU after 2-cycle gap
        ifu_arvalid = 1'b1;
        lsu_arvalid = 1'b1;
        lsu_araddr  = 32'h8000_1000;
        read_txn(2'b10, 32'h8000_1000, 32'h1234_0000, 2'b00, 0, 2);
        lsu_arvalid = 1'b0;
        read_txn(2'b01, 32'h8000_0000, 32'h0000_0517, 2'b00, 0, 1);
        ifu_arvalid = 1'b0;

        // LSU store
        lsu_awaddr  = 32'hA000_03F8;
        lsu_awvalid = 1'b1;
        lsu_wdata   = 32'h41;
        lsu_wstrb   = 4'b0001;
        lsu_wlast   = 1'b1;
        lsu_wvalid  = 1'b1;
        lsu_bready  = 1'b1;
        tick();
        chk("wr_grant", grant, 2'b10);
        chk("wr_m_awvalid", m_awvalid, 1);
        chk("wr_m_awaddr", m_awaddr, 32'hA000_03F8);
        chk("wr_m_wstrb", m_wstrb, 4'b0001);
        chk("wr_m_wdata", m_wdata, 32'h41);
        chk("wr_m_arvalid", m_arvalid, 0);
        m_awready = 1'b1;
        m_wready  = 1'b1;
        #1;
        chk("wr_awready", lsu_awready, 1);
        chk("wr_wready", lsu_wready, 1);
        tick();
        {lsu_awvalid, lsu_wvalid, m_awready, m_wready} = '0;
        chk("wr_hold", grant, 2'b10);
        chk("wr_bvalid_low", lsu_bvalid, 0);
        m_bvalid = 1'b1;
        m_bid    = 4'h3;
        m_bresp  = 2'b00;
        #1;
        chk("wr_bvalid", lsu_bvalid, 1);
        chk("wr_bid", lsu_bid, 4'h3);
        chk("wr_m_bready", m_bready, 1);
        tick();
        m_bvalid = 1'b0;
        chk("wr_end_grant", grant, 0);
        chk("wr_end_busy", busy, 0);

        // Back-pressure with SLVERR
        ifu_arvalid = 1'b1;
        read_txn(2'b01, 32'h8000_0000, 32'hDEAD_BEEF, 2'b10, 5, 1);

        // Reset mid-read, outputs drop without a clock edge
        tick();
        chk("mr_grant", grant, 2'b01);
        chk("mr_m_arvalid", m_arvalid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_rst_arvalid", m_arvalid, 0);
        chk("mr_rst_grant", grant, 0);
        chk("mr_rst_busy", busy, 0);
        #1;
        rst = 1'b0;
        read_txn(2'b01, 32'h8000_0000, 32'h0000_0013, 2'b00, 0, 1);

        // Fairness: both request continuously
        lsu_arvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                read_txn(2'b10, 32'h8000_1000, 32'h100 + i, 2'b00, 0, 1);
            else
                read_txn(2'b01, 32'h8000_0000, 32'h200 + i, 2'b00, 0, 1);
        end
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;
        tick();
        chk("final_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
